// File: rtl/ssd_scan_ctrl_pkg.sv
// Shared seven-segment constants and the hex-to-segment table for the scan controller.
// Segment vectors are active-low in {a,b,c,d,e,f,g} order.
package ssd_scan_ctrl_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [7:0] CATH_DARK = 8'hFF;
    localparam logic       AN_ON     = 1'b0;
    localparam logic       AN_OFF    = 1'b1;

    function automatic logic [6:0] ssd_hex7(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/ssd_hex_decode.sv
// Combinational hex nibble to active-low abcdefg segment decoder.
module ssd_hex_decode
    import ssd_scan_ctrl_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = ssd_hex7(hex_i);

endmodule

// File: rtl/ssd_scan_ctrl.sv
// N-digit time-multiplexed seven-segment scanner with double-buffered, frame-synchronous loading,
// per-digit enable, decimal point, leading-zero blanking and blink.
module ssd_scan_ctrl
    import ssd_scan_ctrl_pkg::*;
#(
    parameter int N_DIGITS     = 8,
    parameter int SCAN_CNT_W   = 17,
    parameter int BLINK_FRAMES = 48
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] digits_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   digit_en,
    input  logic [N_DIGITS-1:0]   blink_mask,
    input  logic                  blank_lz,
    output logic [N_DIGITS-1:0]   an,
    output logic [7:0]            cathodes,
    output logic                  frame_start
);

    localparam int DIG_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DIG_W-1:0] LAST_IDX   = DIG_W'(N_DIGITS - 1);
    localparam logic [FC_W-1:0]  LAST_FRAME = FC_W'(BLINK_FRAMES - 1);

    typedef struct packed {
        logic [4*N_DIGITS-1:0] dig;
        logic [N_DIGITS-1:0]   dp;
        logic [N_DIGITS-1:0]   en;
        logic [N_DIGITS-1:0]   bm;
        logic                  blz;
    } dset_t;

    logic [SCAN_CNT_W-1:0] presc_q, presc_d;
    logic [DIG_W-1:0]      idx_q, idx_d;
    logic [FC_W-1:0]       fcnt_q, fcnt_d;
    logic                  phase_q, phase_d;
    dset_t                 sh_q, sh_d, act_q, act_d;
    logic                  pend_q, pend_d;
    logic [N_DIGITS-1:0]   an_q, an_d;
    logic [7:0]            cath_q, cath_d;
    logic                  fs_q;

    logic                  tick, wrap, xfer;
    logic [N_DIGITS-1:0]   lz;
    logic                  zrun;
    logic [3:0]            sel_hex;
    logic [6:0]            sel_seg;
    logic                  sel_dp, sel_on, sel_lz;

    always_comb begin
        tick    = &presc_q;
        wrap    = tick && (idx_q == LAST_IDX);
        xfer    = wrap && pend_q;
        presc_d = presc_q + SCAN_CNT_W'(1);

        idx_d = idx_q;
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + DIG_W'(1);
        end

        fcnt_d  = fcnt_q;
        phase_d = phase_q;
        if (wrap) begin
            if (fcnt_q == LAST_FRAME) begin
                fcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                fcnt_d = fcnt_q + FC_W'(1);
            end
        end

        // A load on the boundary cycle still transfers the pre-edge shadow and re-arms pending.
        sh_d = sh_q;
        if (load) begin
            sh_d = '{dig: digits_in, dp: dp_in, en: digit_en, bm: blink_mask, blz: blank_lz};
        end
        act_d  = xfer ? sh_q : act_q;
        pend_d = load ? 1'b1 : (xfer ? 1'b0 : pend_q);
    end

    // Slot contents are taken from next-state active set and phase so a new frame is whole.
    always_comb begin
        zrun = 1'b1;
        lz   = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            zrun  = zrun & (act_d.dig[4*k +: 4] == 4'h0);
            lz[k] = act_d.blz & zrun & (k != 0);
        end

        sel_hex = '0;
        sel_dp  = 1'b0;
        sel_on  = 1'b0;
        sel_lz  = 1'b0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (idx_d == DIG_W'(k)) begin
                sel_hex = act_d.dig[4*k +: 4];
                sel_dp  = act_d.dp[k];
                sel_on  = act_d.en[k] & ~(act_d.bm[k] & phase_d);
                sel_lz  = lz[k];
            end
        end
    end

    ssd_hex_decode u_dec (
        .hex_i (sel_hex),
        .seg_o (sel_seg)
    );

    always_comb begin
        an_d   = {N_DIGITS{AN_OFF}};
        cath_d = CATH_DARK;
        if (sel_on) begin
            an_d[idx_d] = AN_ON;
            cath_d      = {(sel_lz ? SEG_BLANK : sel_seg), ~sel_dp};
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            presc_q <= '0;
            idx_q   <= '0;
            fcnt_q  <= '0;
            phase_q <= 1'b0;
            sh_q    <= '0;
            act_q   <= '0;
            pend_q  <= 1'b0;
            an_q    <= {N_DIGITS{AN_OFF}};
            cath_q  <= CATH_DARK;
            fs_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            fcnt_q  <= fcnt_d;
            phase_q <= phase_d;
            sh_q    <= sh_d;
            act_q   <= act_d;
            pend_q  <= pend_d;
            fs_q    <= wrap;
            if (tick) begin
                an_q   <= an_d;
                cath_q <= cath_d;
            end
        end
    end

    assign an          = an_q;
    assign cathodes    = cath_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed scoreboard bench for ssd_scan_ctrl at N_DIGITS=4, SCAN_CNT_W=2, BLINK_FRAMES=2.
module tb_ssd_scan_ctrl;

    logic        clk;
    logic        Reset;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  dp_in, digit_en, blink_mask;
    logic        blank_lz;
    logic [3:0]  an;
    logic [7:0]  cathodes;
    logic        frame_start;

    ssd_scan_ctrl #(.N_DIGITS(4), .SCAN_CNT_W(2), .BLINK_FRAMES(2)) dut (
        .Clk         (clk),
        .Reset       (Reset),
        .load        (load),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .digit_en    (digit_en),
        .blink_mask  (blink_mask),
        .blank_lz    (blank_lz),
        .an          (an),
        .cathodes    (cathodes),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] dig;
        logic [3:0]  dp;
        logic [3:0]  en;
        logic [3:0]  bm;
        logic        blz;
    } dset_t;

    typedef struct {
        int    cyc;
        dset_t s;
    } ld_t;

    logic [6:0] HEX7 [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                              7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                              7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    int          n_cmp = 0;
    int          n_err = 0;
    int          nb    = 0;
    dset_t       m_act, m_sh, m_bl;
    logic        m_pend = 1'b0;
    bit          m_bl_v = 1'b0;
    ld_t         ld_q[$];
    logic [11:0] exp_q[$];

    function automatic dset_t mk(logic [15:0] d, logic [3:0] dp, logic [3:0] en,
                                 logic [3:0] bm, logic blz);
        dset_t s;
        s.dig = d; s.dp = dp; s.en = en; s.bm = bm; s.blz = blz;
        return s;
    endfunction

    function automatic logic [11:0] exp_slot(dset_t s, logic ph, int k);
        logic [15:0] upper;
        logic [3:0]  nib;
        logic [6:0]  seg;
        logic [3:0]  one;
        nib   = s.dig[4*k +: 4];
        upper = s.dig >> (4 * k);
        seg   = (s.blz && (k != 0) && (upper == 16'h0)) ? 7'h7F : HEX7[nib];
        one   = 4'b0001;
        if (!s.en[k] || (s.bm[k] && ph)) return {4'hF, 8'hFF};
        return {~(one << k), seg, ~s.dp[k]};
    endfunction

    task automatic cmp(string tag, logic [12:0] got, logic [12:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: got {fs,an,cath}=%h want %h", tag, got, want);
        end
    endtask

    task automatic drive_set(dset_t s);
        digits_in = s.dig; dp_in = s.dp; digit_en = s.en;
        blink_mask = s.bm; blank_lz = s.blz;
    endtask

    task automatic do_load(dset_t s);
        drive_set(s);
        load = 1'b1;
        @(posedge clk); #1;
        load   = 1'b0;
        m_sh   = s;
        m_pend = 1'b1;
    endtask

    task automatic wait_fs();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(posedge clk); #1;
            load = 1'b0;
            if (frame_start === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        assert (seen) else begin
            n_err++;
            $error("FAIL frame_start_timeout: got no pulse want pulse within 64 cycles");
        end
        if (seen) begin
            nb++;
            if (m_pend) begin m_act = m_sh; m_pend = 1'b0; end
            if (m_bl_v) begin m_sh = m_bl; m_pend = 1'b1; m_bl_v = 1'b0; end
        end
    endtask

    task automatic check_frame(string tag);
        logic        ph;
        logic [11:0] e;
        ld_t         ld;
        wait_fs();
        ph = ((nb / 2) % 2) == 1;
        for (int k = 0; k < 4; k++) exp_q.push_back(exp_slot(m_act, ph, k));
        e = 12'h0;
        for (int c = 0; c < 16; c++) begin
            if (c != 0) begin @(posedge clk); #1; end
            load = 1'b0;
            if (c % 4 == 0) e = exp_q.pop_front();
            cmp($sformatf("%s_f%0d_c%0d", tag, nb, c), {frame_start, an, cathodes}, {(c == 0), e});
            if (ld_q.size() > 0 && ld_q[0].cyc == c) begin
                ld = ld_q.pop_front();
                drive_set(ld.s);
                load = 1'b1;
                if (c == 15) begin m_bl = ld.s; m_bl_v = 1'b1; end
                else begin m_sh = ld.s; m_pend = 1'b1; end
            end
        end
    endtask

    initial begin
        dset_t s1234, sabcd, s9999, s0050, sblink, sen, sc0de, sfin;
        s1234  = mk(16'h1234, 4'h0, 4'hF, 4'h0, 1'b0);
        sabcd  = mk(16'hABCD, 4'h0, 4'hF, 4'h0, 1'b0);
        s9999  = mk(16'h9999, 4'hF, 4'hF, 4'h0, 1'b0);
        s0050  = mk(16'h0050, 4'b0100, 4'hF, 4'h0, 1'b1);
        sblink = mk(16'h1234, 4'h0, 4'hF, 4'b0010, 1'b0);
        sen    = mk(16'h8E0F, 4'b1001, 4'b0101, 4'h0, 1'b0);
        sc0de  = mk(16'hC0DE, 4'b0010, 4'hF, 4'h0, 1'b1);
        sfin   = mk(16'h00F7, 4'b0001, 4'hF, 4'h0, 1'b1);
        m_act = '0; m_sh = '0; m_bl = '0;
        Reset = 1'b1; load = 1'b0;
        drive_set('0);

        repeat (3) @(posedge clk);
        #1;
        cmp("reset_state", {frame_start, an, cathodes}, {1'b0, 4'hF, 8'hFF});
        @(posedge clk); #1;
        cmp("reset_hold", {frame_start, an, cathodes}, {1'b0, 4'hF, 8'hFF});
        Reset = 1'b0;

        do_load(s1234);
        cmp("dark_before_frame0", {frame_start, an, cathodes}, {1'b0, 4'hF, 8'hFF});
        @(posedge clk); #1;
        cmp("dark_before_frame1", {frame_start, an, cathodes}, {1'b0, 4'hF, 8'hFF});
        check_frame("t1_1234");

        ld_q.push_back('{cyc: 5, s: sabcd});
        check_frame("t2_no_tear");
        check_frame("t2_abcd");

        ld_q.push_back('{cyc: 3, s: s9999});
        ld_q.push_back('{cyc: 10, s: s0050});
        check_frame("t3_still_abcd");
        check_frame("t3_lz_0050");

        ld_q.push_back('{cyc: 4, s: sblink});
        check_frame("t4_pre");
        for (int f = 0; f < 4; f++) check_frame($sformatf("t4_blink%0d", f));
        ld_q.push_back('{cyc: 6, s: sen});
        check_frame("t4_last");
        check_frame("en_partial");

        ld_q.push_back('{cyc: 15, s: sc0de});
        check_frame("t6_pre");
        check_frame("t6_hold");
        check_frame("t6_new");

        wait_fs();
        repeat (8) begin @(posedge clk); #1; end
        Reset = 1'b1;
        @(posedge clk); #1;
        cmp("t5_reset_mid", {frame_start, an, cathodes}, {1'b0, 4'hF, 8'hFF});
        Reset = 1'b0;
        m_act = '0; m_sh = '0; m_pend = 1'b0; m_bl_v = 1'b0; nb = 0;
        ld_q.delete();
        check_frame("t5_dark_a");
        ld_q.push_back('{cyc: 2, s: sfin});
        check_frame("t5_dark_b");
        check_frame("t5_reload");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
